// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the PC redirect controller: FSM encoding, reset PC,
// instruction field widths and a saturating counter helper.
package pc_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_KILL  = 2'd2
  } pc_state_t;

  localparam logic [31:0] PKG_RESET_PC = 32'h0000_0000;
  localparam int          JIDX_W       = 26;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_jump_target_calc.sv
// J/JAL target former: upper PC+4 region bits joined with the word index
// shifted left by two.
module jump_target_calc
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] id_pc4,
  input  logic [JIDX_W-1:0] jump_idx,
  output logic [ADDR_W-1:0] target
);

  localparam logic [ADDR_W-1:0] REGION_MASK =
    {{(ADDR_W-JIDX_W-2){1'b1}}, {(JIDX_W+2){1'b0}}};

  logic [ADDR_W-1:0] idx_ext;

  always_comb begin
    idx_ext = ADDR_W'(jump_idx);
    target  = (id_pc4 & REGION_MASK) | (idx_ext << 2);
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC owner and fetch sequencer with branch/JR/jump redirect arbitration.
// Optional event counters are enabled by defining PC_REDIRECT_STATS_EN.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PKG_RESET_PC)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              jump_i,
  input  logic [25:0]       jump_idx_i,
  input  logic [ADDR_W-1:0] id_pc4_i,
  input  logic              jr_i,
  input  logic [ADDR_W-1:0] jr_addr_i,
  input  logic              fetch_ack_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              fetch_req_o,
  output logic              if_valid_o,
  output logic              flush_ifid_o,
  output logic              flush_idex_o
`ifdef PC_REDIRECT_STATS_EN
  ,
  output logic [31:0]       stat_br_o,
  output logic [31:0]       stat_jmp_o,
  output logic [31:0]       stat_kill_o
`endif
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  pc_state_t         state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] jmp_target;
  logic [ADDR_W-1:0] redir_target;
  logic              acc_br, acc_jr, acc_jmp, redir_acc;

  jump_target_calc #(.ADDR_W(ADDR_W)) u_jump_target_calc (
    .id_pc4   (id_pc4_i),
    .jump_idx (jump_idx_i),
    .target   (jmp_target)
  );

  // Branch is the oldest source and never stalls; ID sources wait out a stall.
  always_comb begin
    acc_br    = br_taken_i;
    acc_jr    = !br_taken_i && jr_i && !stall_i;
    acc_jmp   = !br_taken_i && !jr_i && jump_i && !stall_i;
    redir_acc = acc_br || acc_jr || acc_jmp;
    if (acc_br)      redir_target = br_target_i & ALIGN_MASK;
    else if (acc_jr) redir_target = jr_addr_i & ALIGN_MASK;
    else             redir_target = jmp_target & ALIGN_MASK;
  end

  always_comb begin
    pc_o         = pc_q;
    fetch_req_o  = (state_q == ST_FETCH);
    if_valid_o   = rst_i && (state_q == ST_FETCH) && fetch_ack_i && !redir_acc;
    flush_ifid_o = rst_i && redir_acc;
    flush_idex_o = rst_i && acc_br;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_FETCH;
          if (redir_acc) pc_q <= redir_target;
        end
        ST_FETCH: begin
          if (redir_acc) begin
            pc_q <= redir_target;
            if (!fetch_ack_i) state_q <= ST_KILL;
          end else if (fetch_ack_i && !stall_i) begin
            pc_q <= pc_q + ADDR_W'(4);
          end
        end
        // The stale ack only retires the old request; nothing is delivered.
        ST_KILL: begin
          if (redir_acc) pc_q <= redir_target;
          if (fetch_ack_i) state_q <= ST_FETCH;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef PC_REDIRECT_STATS_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stat_br_o   <= 32'd0;
      stat_jmp_o  <= 32'd0;
      stat_kill_o <= 32'd0;
    end else begin
      if (acc_br) stat_br_o <= sat_inc(stat_br_o);
      if (acc_jr || acc_jmp) stat_jmp_o <= sat_inc(stat_jmp_o);
      if ((state_q == ST_FETCH) && redir_acc && !fetch_ack_i)
        stat_kill_o <= sat_inc(stat_kill_o);
    end
  end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: directed scenarios then random traffic
// against a behavioural fetch model; counters checked when PC_REDIRECT_STATS_EN.
module tb_pc_redirect_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic        req;
    logic        ifv;
    logic        fi;
    logic        fx;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        br_taken_i = 1'b0;
  logic [31:0] br_target_i = '0;
  logic        jump_i = 1'b0;
  logic [25:0] jump_idx_i = '0;
  logic [31:0] id_pc4_i = '0;
  logic        jr_i = 1'b0;
  logic [31:0] jr_addr_i = '0;
  logic        fetch_ack_i = 1'b0;
  logic [31:0] pc_o;
  logic        fetch_req_o, if_valid_o, flush_ifid_o, flush_idex_o;
`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] stat_br_o, stat_jmp_o, stat_kill_o;
`endif

  pc_redirect_ctrl #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .stall_i      (stall_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .jump_i       (jump_i),
    .jump_idx_i   (jump_idx_i),
    .id_pc4_i     (id_pc4_i),
    .jr_i         (jr_i),
    .jr_addr_i    (jr_addr_i),
    .fetch_ack_i  (fetch_ack_i),
    .pc_o         (pc_o),
    .fetch_req_o  (fetch_req_o),
    .if_valid_o   (if_valid_o),
    .flush_ifid_o (flush_ifid_o),
    .flush_idex_o (flush_idex_o)
`ifdef PC_REDIRECT_STATS_EN
    ,
    .stat_br_o    (stat_br_o),
    .stat_jmp_o   (stat_jmp_o),
    .stat_kill_o  (stat_kill_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  // Reference model: PC value, whether fetching has started, whether a stale
  // request is being drained, and event tallies.
  logic [31:0] m_pc = 32'h0;
  bit          m_run = 1'b0;
  bit          m_kill = 1'b0;
  int          m_br = 0, m_jmp = 0, m_kills = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_o", pc_o, e.pc);
        chk("fetch_req_o", 32'(fetch_req_o), 32'(e.req));
        chk("if_valid_o", 32'(if_valid_o), 32'(e.ifv));
        chk("flush_ifid_o", 32'(flush_ifid_o), 32'(e.fi));
        chk("flush_idex_o", 32'(flush_idex_o), 32'(e.fx));
      end
    end
  end

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cycle(input logic br, input logic [31:0] bt, input logic j,
                       input logic [25:0] ji, input logic [31:0] p4, input logic jr,
                       input logic [31:0] ja, input logic st, input logic ack);
    exp_t        e;
    logic        abr, ajr, aj, acc;
    logic [31:0] tgt;
    br_taken_i = br; br_target_i = bt; jump_i = j; jump_idx_i = ji;
    id_pc4_i = p4; jr_i = jr; jr_addr_i = ja; stall_i = st; fetch_ack_i = ack;
    abr = br;
    ajr = !br && jr && !st;
    aj  = !br && !jr && j && !st;
    acc = abr || ajr || aj;
    if (abr)      tgt = bt;
    else if (ajr) tgt = ja;
    else          tgt = {p4[31:28], ji, 2'b00};
    tgt[1:0] = 2'b00;
    e.pc  = m_pc;
    e.req = m_run && !m_kill;
    e.ifv = m_run && !m_kill && ack && !acc;
    e.fi  = acc;
    e.fx  = abr;
    exp_q.push_back(e);
    @(posedge clk_i);
    if (abr) m_br++;
    if (ajr || aj) m_jmp++;
    if (!m_run) begin
      m_run = 1'b1;
      if (acc) m_pc = tgt;
    end else if (m_kill) begin
      if (acc) m_pc = tgt;
      if (ack) m_kill = 1'b0;
    end else if (acc) begin
      m_pc = tgt;
      if (!ack) begin m_kill = 1'b1; m_kills++; end
    end else if (ack && !st) begin
      m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  task automatic plain(input logic st, input logic ack);
    cycle(1'b0, 32'h0, 1'b0, 26'h0, 32'h0, 1'b0, 32'h0, st, ack);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".pc"}, pc_o, 32'h0);
    chk({tag, ".req"}, 32'(fetch_req_o), 32'h0);
    chk({tag, ".ifv"}, 32'(if_valid_o), 32'h0);
    chk({tag, ".fi"}, 32'(flush_ifid_o), 32'h0);
    chk({tag, ".fx"}, 32'(flush_idex_o), 32'h0);
`ifdef PC_REDIRECT_STATS_EN
    chk({tag, ".stat_br"}, stat_br_o, 32'h0);
    chk({tag, ".stat_jmp"}, stat_jmp_o, 32'h0);
    chk({tag, ".stat_kill"}, stat_kill_o, 32'h0);
`endif
  endtask

  initial begin
    // Power-on reset, with redirect/ack inputs active to show they are masked.
    #2 rst_i = 1'b0;
    br_taken_i = 1'b1; jump_i = 1'b1; fetch_ack_i = 1'b1;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;

    // IDLE with a stale ack, then sequential fetch 0,4,8,C.
    plain(1'b0, 1'b1);
    repeat (4) plain(1'b0, 1'b1);
    chk("seq_pc", pc_o, 32'h0000_0010);

    // J with ack in the same cycle.
    cycle(1'b0, 32'h0, 1'b1, 26'h0000010, 32'h0040_0008, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("jump_pc", pc_o, 32'h0000_0040);

    // Branch and jump together: branch wins.
    cycle(1'b1, 32'h0000_0100, 1'b1, 26'h3FFFFFF, 32'hF000_0000, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("br_over_jump_pc", pc_o, 32'h0000_0100);

    // Redirect with request pending -> drain stale ack three cycles later.
    cycle(1'b0, 32'h0, 1'b0, 26'h0, 32'h0, 1'b1, 32'h0000_0203, 1'b0, 1'b0);
    plain(1'b0, 1'b0);
    plain(1'b0, 1'b0);
    plain(1'b0, 1'b1);
    chk("kill_req", 32'(fetch_req_o), 32'h1);
    chk("kill_pc", pc_o, 32'h0000_0200);

    // JR under stall is held off, then taken.
    cycle(1'b0, 32'h0, 1'b0, 26'h0, 32'h0, 1'b1, 32'h1234_5677, 1'b1, 1'b1);
    chk("stall_jr_pc", pc_o, 32'h0000_0200);
    cycle(1'b0, 32'h0, 1'b0, 26'h0, 32'h0, 1'b1, 32'h1234_5677, 1'b0, 1'b1);
    chk("jr_pc", pc_o, 32'h1234_5674);

    // PC increment wraps.
    cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    plain(1'b0, 1'b1);
    chk("wrap_pc", pc_o, 32'h0000_0000);

    // Async reset in the middle of a KILL cycle.
    cycle(1'b1, 32'h0000_0300, 1'b0, 26'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("pre_rst_req", 32'(fetch_req_o), 32'h0);
    @(negedge clk_i);
    #1;
    br_taken_i = 1'b1; jr_i = 1'b1; fetch_ack_i = 1'b1;
    rst_i = 1'b0;
    #1 check_reset_outputs("mid_kill_rst");
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    m_pc = 32'h0; m_run = 1'b0; m_kill = 1'b0;
    m_br = 0; m_jmp = 0; m_kills = 0;
    plain(1'b0, 1'b1);
    plain(1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(7) == 0), $urandom, ($urandom_range(5) == 0),
            26'($urandom), $urandom, ($urandom_range(7) == 0), $urandom,
            ($urandom_range(4) == 0), ($urandom_range(1) == 0));
    end

    br_taken_i = 1'b0; jump_i = 1'b0; jr_i = 1'b0; stall_i = 1'b0; fetch_ack_i = 1'b0;
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk_i);
    #1 chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
`ifdef PC_REDIRECT_STATS_EN
    chk("stat_br", stat_br_o, 32'(m_br));
    chk("stat_jmp", stat_jmp_o, 32'(m_jmp));
    chk("stat_kill", stat_kill_o, 32'(m_kills));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
